dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words in the internal data array.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted between request accept and response (legal 0..15).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a memory request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 req_ready  output  1  responder can accept a request this cycle.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected (misaligned, illegal size, or out of range); valid with rsp_valid.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; at most one request outstanding.
REQ-016 req_ready SHALL be 1 only in IDLE while reset is low; accept occurs on an edge where req_ready=1 and req_valid=1.
REQ-017 On accept, req_we, req_addr, req_size, req_unsigned, req_wdata SHALL be registered; later input changes SHALL not affect the request.
REQ-018 IDLE -> WAIT on accept if WAIT_CYCLES>0, else IDLE -> RESP; WAIT SHALL last exactly WAIT_CYCLES cycles, then -> RESP; RESP lasts one cycle, then -> IDLE.
REQ-019 Latency: rsp_valid SHALL be high for exactly one cycle, beginning WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 req_valid high during WAIT/RESP SHALL be ignored (not queued); the earliest next accept is the cycle after RESP.
REQ-021 Error if: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; or addr >= 4*DEPTH_WORDS.
REQ-022 Word index SHALL be addr[31:2]; byte lanes little-endian: lane n = bits [8n+7:8n], n = addr[1:0].
REQ-023 Store without error SHALL update only the addressed lanes (byte: 1 lane; half: lanes addr[1]*2..+1; word: all), committed on the edge ending the RESP cycle.
REQ-024 Erroneous request SHALL not modify memory; rsp_err=1, rsp_rdata=0.
REQ-025 Load SHALL extract the addressed byte/halfword/word and sign- or zero-extend it to 32 bits per req_unsigned (ignored for word).
REQ-026 rsp_rdata and rsp_err SHALL be registered and SHALL hold their values until the next RESP cycle; rsp_err=0 for successful requests.
REQ-027 Store response SHALL carry rsp_rdata=0; a load in the cycle after a store to the same word SHALL return the updated data.

Reset
REQ-028 While reset=1 the FSM SHALL go to IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 after the reset edge.
REQ-029 Reset during WAIT or RESP SHALL abandon the request: no memory write, no rsp_valid.
REQ-030 Memory contents SHALL not be altered by reset (array zero at time 0).
REQ-031 First accept SHALL be possible in the first cycle with reset=0.

Verification
REQ-032 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2); load returns 0xDEADBEEF, rsp_err=0.
REQ-033 Store byte 0x80 @0x11 over 0x00000000, then lb @0x11 -> 0xFFFFFF80; lbu @0x11 -> 0x00000080; lw @0x10 -> 0x00008000.
REQ-034 Store half 0xABCD @0x22, then lh @0x22 -> 0xFFFFABCD; lhu -> 0x0000ABCD; lw @0x20 -> 0xABCD0000.
REQ-035 lh @0x01, lw @0x06, size=11 @0x0, sw @0x1000 (DEPTH_WORDS=1024) -> each rsp_err=1, rsp_rdata=0; subsequent lw of the affected words unchanged.
REQ-036 Assert reset in the WAIT cycle of sw 0x12345678 @0x40 -> no rsp_valid; after release, lw @0x40 returns the prior value.
REQ-037 Hold req_valid=1 continuously with distinct addresses -> exactly one accept per WAIT_CYCLES+2 cycles, req_ready low between, no request lost or duplicated.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// ----------------------------------------------------------------------------
// Single-outstanding data-memory responder with a fixed number of wait states.
// A request is accepted in IDLE, optionally waits WAIT_CYCLES cycles, is
// evaluated in a one-cycle RESP state, and the registered response strobe
// appears in the cycle after RESP. In that same cycle the responder is back
// in IDLE and can accept the next request. Stores are committed on the edge
// that ends RESP.
//
// Parameters
//   DEPTH_WORDS   number of 32-bit words in the internal array
//   WAIT_CYCLES   wait states between accept and RESP (0..15)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset (memory contents untouched)
//   req_valid     request present
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata     right-aligned store data
//   req_ready     request can be accepted this cycle (IDLE and not in reset)
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     extended load data (0 for stores and errors), held
//   rsp_err       request rejected (misaligned, illegal size, out of range)
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    // Only meaningful when WAIT_CYCLES > 0; WAIT is never entered otherwise.
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  wait_cnt_r;

    // Request captured on accept; later input changes do not affect it.
    logic        we_r;
    logic [31:0] addr_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [31:0] wdata_r;

    logic [31:0] mem_r [DEPTH_WORDS];

    logic             size_err_s;
    logic             range_err_s;
    logic             err_s;
    logic [3:0]       be_s;
    logic [31:0]      wlanes_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      rd_shift_s;
    logic [31:0]      load_data_s;

    // Sign- or zero-extend the right-aligned load data to 32 bits.
    function automatic logic [31:0] extend_load(input logic [1:0]  size,
                                                input logic        uns,
                                                input logic [31:0] data);
        logic [31:0] res;
        case (size)
            2'b00:   res = uns ? {24'h000000, data[7:0]}  : {{24{data[7]}}, data[7:0]};
            2'b01:   res = uns ? {16'h0000, data[15:0]}   : {{16{data[15]}}, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    // Ready is visible in the very first cycle after reset deasserts.
    assign req_ready = (state_r == IDLE) && !reset;

    // Size/alignment decode plus byte-enable and lane replication for stores.
    always_comb begin
        size_err_s = 1'b0;
        be_s       = 4'b0000;
        wlanes_s   = 32'h0000_0000;
        case (size_r)
            2'b00: begin
                be_s     = 4'b0001 << addr_r[1:0];
                wlanes_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                size_err_s = addr_r[0];
                be_s       = addr_r[1] ? 4'b1100 : 4'b0011;
                wlanes_s   = {2{wdata_r[15:0]}};
            end
            2'b10: begin
                size_err_s = (addr_r[1:0] != 2'b00);
                be_s       = 4'b1111;
                wlanes_s   = wdata_r;
            end
            default: begin
                size_err_s = 1'b1;
            end
        endcase
    end

    assign range_err_s = ({1'b0, addr_r} >= MEM_BYTES);
    assign err_s       = size_err_s | range_err_s;

    // Index is only used when the address is in range.
    assign idx_s       = addr_r[IDX_W+1:2];
    assign rd_word_s   = mem_r[idx_s];
    assign rd_shift_s  = rd_word_s >> {addr_r[1:0], 3'b000};
    assign load_data_s = extend_load(size_r, unsigned_r, rd_shift_s);

    // Control FSM with captured request and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
            we_r       <= 1'b0;
            addr_r     <= 32'h0000_0000;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r       <= req_we;
                        addr_r     <= req_addr;
                        size_r     <= req_size;
                        unsigned_r <= req_unsigned;
                        wdata_r    <= req_wdata;
                        wait_cnt_r <= 4'd0;
                        state_r    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_s;
                    rsp_rdata <= (we_r || err_s) ? 32'h0000_0000 : load_data_s;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Commit store lanes on the edge that ends RESP; reset abandons the write.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == RESP) && we_r && !err_s) begin
            for (int n = 0; n < 4; n++) begin
                if (be_s[n]) begin
                    mem_r[idx_s][8*n +: 8] <= wlanes_s[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_dmem_responder;

    localparam int LAT = 3;   // response strobe seen 3 edges after the accept edge

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                input logic uns, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = a; v.sz = sz; v.uns = uns; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    // One request/response; lat = edges from accept to strobe, 99 on timeout.
    // Called at posedge+1; returns at posedge+1 in the strobe cycle.
    task automatic xact(input vec_t v, output logic [31:0] rd, output logic er, output int lat);
        int w = 0;
        req_we = v.we; req_addr = v.addr; req_size = v.sz;
        req_unsigned = v.uns; req_wdata = v.wd; req_valid = 1'b1;
        while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
        lat = 99; rd = 32'hxxxx_xxxx; er = 1'bx;
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(posedge clk); #1;
        // scramble inputs after accept; the captured request must be used
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
        req_we = ~v.we; req_size = 2'b11; req_unsigned = ~v.uns;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err;
        if (!rsp_valid) lat = 99;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        req_valid = 1'b0; reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_release: got %b want 1", req_ready); end
    endtask

    task automatic test_word();
        vec_t v[$]; logic [31:0] rd; logic er; int lat;
        v.push_back(mk(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0));
        v.push_back(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0));
        for (int i = 0; i < v.size(); i++) begin
            xact(v[i], rd, er, lat);
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL word[%0d] latency: got %0d want %0d", i, lat, LAT); end
            n_cmp++; if (rd !== v[i].exp_rd) begin n_bad++; $display("FAIL word[%0d] rdata: got %h want %h", i, rd, v[i].exp_rd); end
            n_cmp++; if (er !== v[i].exp_err) begin n_bad++; $display("FAIL word[%0d] err: got %b want %b", i, er, v[i].exp_err); end
        end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL word_strobe_one_cycle: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word_rdata_hold: got %h want deadbeef", rsp_rdata); end
    endtask

    task automatic test_byte();
        vec_t v[$]; logic [31:0] rd; logic er; int lat;
        v.push_back(mk(1'b1, 32'h10, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 1'b0));
        v.push_back(mk(1'b1, 32'h11, 2'b00, 1'b0, 32'h55AA_5580, 32'h0, 1'b0));
        v.push_back(mk(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0));
        v.push_back(mk(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'h0000_0080, 1'b0));
        v.push_back(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0000_8000, 1'b0));
        v.push_back(mk(1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_007F, 32'h0, 1'b0));
        v.push_back(mk(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'h0000_007F, 1'b0));
        v.push_back(mk(1'b0, 32'h12, 2'b00, 1'b1, 32'h0, 32'h0000_0000, 1'b0));
        v.push_back(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h7F00_8000, 1'b0));
        for (int i = 0; i < v.size(); i++) begin
            xact(v[i], rd, er, lat);
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL byte[%0d] latency: got %0d want %0d", i, lat, LAT); end
            n_cmp++; if (rd !== v[i].exp_rd) begin n_bad++; $display("FAIL byte[%0d] rdata: got %h want %h", i, rd, v[i].exp_rd); end
            n_cmp++; if (er !== v[i].exp_err) begin n_bad++; $display("FAIL byte[%0d] err: got %b want %b", i, er, v[i].exp_err); end
        end
    endtask

    task automatic test_half();
        vec_t v[$]; logic [31:0] rd; logic er; int lat;
        v.push_back(mk(1'b1, 32'h20, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 1'b0));
        v.push_back(mk(1'b1, 32'h22, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0, 1'b0));
        v.push_back(mk(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 32'hFFFF_ABCD, 1'b0));
        v.push_back(mk(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 32'h0000_ABCD, 1'b0));
        v.push_back(mk(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hABCD_0000, 1'b0));
        v.push_back(mk(1'b0, 32'h20, 2'b01, 1'b0, 32'h0, 32'h0000_0000, 1'b0));
        v.push_back(mk(1'b1, 32'h20, 2'b01, 1'b0, 32'h0000_7FFF, 32'h0, 1'b0));
        v.push_back(mk(1'b0, 32'h20, 2'b01, 1'b0, 32'h0, 32'h0000_7FFF, 1'b0));
        v.push_back(mk(1'b0, 32'h20, 2'b10, 1'b1, 32'h0, 32'hABCD_7FFF, 1'b0));
        for (int i = 0; i < v.size(); i++) begin
            xact(v[i], rd, er, lat);
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL half[%0d] latency: got %0d want %0d", i, lat, LAT); end
            n_cmp++; if (rd !== v[i].exp_rd) begin n_bad++; $display("FAIL half[%0d] rdata: got %h want %h", i, rd, v[i].exp_rd); end
            n_cmp++; if (er !== v[i].exp_err) begin n_bad++; $display("FAIL half[%0d] err: got %b want %b", i, er, v[i].exp_err); end
        end
    endtask

    task automatic test_errors();
        vec_t v[$]; logic [31:0] rd; logic er; int lat;
        v.push_back(mk(1'b1, 32'h000, 2'b10, 1'b0, 32'h1111_2222, 32'h0, 1'b0));
        v.push_back(mk(1'b1, 32'h004, 2'b10, 1'b0, 32'h3333_4444, 32'h0, 1'b0));
        v.push_back(mk(1'b1, 32'hFFC, 2'b10, 1'b0, 32'h0BAD_F00D, 32'h0, 1'b0));
        v.push_back(mk(1'b0, 32'h001, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1));
        v.push_back(mk(1'b1, 32'h001, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1));
        v.push_back(mk(1'b0, 32'h006, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1));
        v.push_back(mk(1'b1, 32'h006, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1));
        v.push_back(mk(1'b0, 32'h000, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1));
        v.push_back(mk(1'b1, 32'h000, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1));
        v.push_back(mk(1'b1, 32'h1000, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1));
        v.push_back(mk(1'b0, 32'h1000, 2'b00, 1'b1, 32'h0, 32'h0, 1'b1));
        v.push_back(mk(1'b0, 32'h000, 2'b10, 1'b0, 32'h0, 32'h1111_2222, 1'b0));
        v.push_back(mk(1'b0, 32'h004, 2'b10, 1'b0, 32'h0, 32'h3333_4444, 1'b0));
        v.push_back(mk(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0));
        v.push_back(mk(1'b0, 32'h002, 2'b01, 1'b1, 32'h0, 32'h0000_1111, 1'b0));
        for (int i = 0; i < v.size(); i++) begin
            xact(v[i], rd, er, lat);
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL err[%0d] latency: got %0d want %0d", i, lat, LAT); end
            n_cmp++; if (rd !== v[i].exp_rd) begin n_bad++; $display("FAIL err[%0d] rdata: got %h want %h", i, rd, v[i].exp_rd); end
            n_cmp++; if (er !== v[i].exp_err) begin n_bad++; $display("FAIL err[%0d] err: got %b want %b", i, er, v[i].exp_err); end
        end
    endtask

    // Abort a store to 0x40 by reset in WAIT (pass 0) or in RESP (pass 1).
    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int pulses;
        xact(mk(1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0), rd, er, lat);
        for (int pass = 0; pass < 2; pass++) begin
            xact(mk(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0), rd, er, lat);
            n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL abort%0d pre_load: got %h want cafef00d", pass, rd); end
            req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0;
            req_wdata = 32'h1234_5678; req_valid = 1'b1;
            @(posedge clk); #1;                 // accept edge; now in first WAIT cycle
            req_valid = 1'b0;
            if (pass == 1) begin
                repeat (2) @(posedge clk);      // now in RESP
                #1;
            end
            reset = 1'b1;
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort%0d rsp_valid: got %b want 0", pass, rsp_valid); end
            n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL abort%0d rdata: got %h want 0", pass, rsp_rdata); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL abort%0d ready: got %b want 0", pass, req_ready); end
            @(posedge clk); #1;
            reset = 1'b0;
            pulses = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (rsp_valid) pulses++;
            end
            n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort%0d stray_rsp: got %0d want 0", pass, pulses); end
            xact(mk(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0), rd, er, lat);
            n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL abort%0d mem: got %h want cafef00d", pass, rd); end
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL abort%0d latency: got %0d want %0d", pass, lat, LAT); end
        end
    endtask

    // req_valid held high across four distinct stores, then read back.
    task automatic test_back_to_back();
        int acc_cyc[$]; int k = 0; int cyc = 0; int pulses = 0;
        logic acc; logic [31:0] rd; logic er; int lat;
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'hB000_0000; req_valid = 1'b1;
        while (cyc < 40 && (k < 4 || cyc < acc_cyc[acc_cyc.size()-1] + 6)) begin
            acc = req_ready && req_valid;
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid) pulses++;
            if (acc) begin
                acc_cyc.push_back(cyc);
                k++;
                if (k < 4) begin
                    req_addr = 32'h100 + 32'(4 * k);
                    req_wdata = 32'hB000_0000 | 32'(k);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (acc_cyc.size() !== 4) begin n_bad++; $display("FAIL b2b accepts: got %0d want 4", acc_cyc.size()); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 4) begin
                n_bad++; $display("FAIL b2b spacing[%0d]: got %0d want 4", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL b2b responses: got %0d want 4", pulses); end
        for (int i = 0; i < 4; i++) begin
            xact(mk(1'b0, 32'h100 + 32'(4 * i), 2'b10, 1'b0, 32'h0, 32'h0, 1'b0), rd, er, lat);
            n_cmp++;
            if (rd !== (32'hB000_0000 | 32'(i))) begin
                n_bad++; $display("FAIL b2b readback[%0d]: got %h want %h", i, rd, 32'hB000_0000 | 32'(i));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
